crossbar_arbiter: RTL
=====================

# crossbar_arbiter

Per-slave round-robin arbiter for the 4x4 request/ack crossbar; sits directly upstream of the commutation block and produces its `granted_matrix`. It decodes each master's target slave from the top address bits and holds one grant per slave until that slave's `session_is_finished` pulse. A per-slave watchdog force-releases a grant that is never completed.

## Interface
- QTY_OF_DEVICES, 4, number of masters and number of slaves; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 0, maximum number of cycles a grant may stay in GRANTED; 0 disables the watchdog.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- master_req  input  [QTY_OF_DEVICES]  per-master request level, taken from the master's `_req`.
- master_addr  input  [QTY_OF_DEVICES][ADDR_WIDTH]  per-master address, taken from the master's `_addr`.
- session_is_finished  input  [QTY_OF_DEVICES]  per-slave one-cycle completion pulse from the commutation block.
- granted_matrix  output  [QTY_OF_DEVICES][QTY_OF_DEVICES]  indexed [slave][master]; each row is one-hot or zero.
- master_granted  output  [QTY_OF_DEVICES]  bit m is high when any slave currently grants master m.
- session_timeout  output  [QTY_OF_DEVICES]  per-slave one-cycle pulse raised when the watchdog fires.

## Operation
- **Target decode:** SW = log2(QTY_OF_DEVICES). The target slave of master m is `master_addr[m][ADDR_WIDTH-1 -: SW]`. Master m requests slave s when `master_req[m]` is high and the decoded target equals s.
- **Per-slave FSM:** two states, IDLE and GRANTED.
  - IDLE: if the request vector for slave s is nonzero, register the round-robin winner into `grant_q[s]` and enter GRANTED.
  - GRANTED: hold `grant_q[s]` unchanged. Master `req` and `addr` changes are ignored while granted.
  - GRANTED -> IDLE on `session_is_finished[s]` or on watchdog expiry.
- **Round robin:** `ptr[s]` points to the highest-priority master. The search runs ptr, ptr+1, … mod QTY_OF_DEVICES. On each release, `ptr[s]` becomes (granted master + 1) mod QTY_OF_DEVICES.
- **Output masking:** `granted_matrix[s] = grant_q[s] & ~{QTY_OF_DEVICES{session_is_finished[s]}}`. The grant therefore drops combinationally in the finish cycle, and the slave mux cannot restart a session on a stale grant.
- **Gap between sessions:** after a release, a slave spends at least one cycle in IDLE with a zero row. No re-arbitration happens on the release edge.
- **Master exclusivity:** a master already granted by any slave is excluded from arbitration at every other slave. A master therefore appears at most once in any column.
- **Watchdog:** when TIMEOUT_CYCLES > 0, a counter `cnt[s]` clears on entry to GRANTED and increments each cycle spent in GRANTED.
  - When `cnt[s] == TIMEOUT_CYCLES-1` and `session_is_finished[s]` is low, the slave releases to IDLE and pulses `session_timeout[s]` for one cycle.
  - `ptr[s]` advances on a timeout release exactly as on a normal release.
- **Simultaneous finish and timeout:** finish wins; no timeout pulse is raised.
- **Reset values:** all `grant_q` zero, all `ptr` zero, all `cnt` zero, all FSMs IDLE. Every output is 0 during reset.
- **Reset mid-session:** the grant is dropped immediately (asynchronously) and the pointers restart at 0.

## Timing
- **Request to grant:** a request sampled on edge k gives a `granted_matrix` bit that is high from after edge k. Latency is one cycle.
- **Finish pulse:** `session_is_finished[s]` high in cycle c makes the row zero in cycle c (combinational). The FSM is IDLE after edge c.
- **Earliest re-grant:** the next grant is sampled on edge c+1 and is visible in cycle c+2.
- **`master_granted`:** combinational OR down each column of the masked `granted_matrix`.
- **Watchdog release:** the grant is high for exactly TIMEOUT_CYCLES cycles. `session_timeout` is high in the cycle after the release edge.

## Structure
- Shared package `arbiter_pkg` contains:
  - `arb_state_t` enum {IDLE, GRANTED}.
  - `SLAVE_SEL_W` localparam.
  - `ADDR_WIDTH`, imported from `interface_connection`.
- Sub-module `rr_arbiter_slice`: one instance per slave, containing the FSM, pointer, watchdog counter and grant register.
- The top level contains the decode, the cross-slave exclusion mask, output masking and the `master_granted` OR.
- The sub-module is instanced in a generate loop; no interfaces cross this block.

## Test plan
- **Single request:** after reset, master 1 requests addr 0x8000_0000 (slave 2) -> `granted_matrix[2] = 4'b0010` one cycle later. Pulse `session_is_finished[2]` -> the row goes 0 in the same cycle.
- **Round-robin fairness:** masters 0, 1 and 3 all hold requests for slave 0 with ptr=0 -> grant order is 0, 1, 3, 0 across four sessions, with one zero cycle between each.
- **Parallel sessions:** masters 0..3 target slaves 3, 2, 1, 0 -> all four rows are granted on the same cycle, anti-diagonal one-hot, and each `master_granted` bit is 1.
- **Exclusivity:** master 2 is granted by slave 1, and a second request decode from master 2 points to slave 3 -> slave 3 row stays 0 until slave 1 releases.
- **Watchdog:** with TIMEOUT_CYCLES=8 and no finish pulse -> the grant lasts 8 cycles, `session_timeout[s]` pulses once, and the pointer advances. With finish and expiry in the same cycle -> no timeout pulse.
- **Reset mid-session:** assert rst_n low during GRANTED -> all outputs 0 asynchronously. After deassertion, the first grant follows priority from master 0.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and widths for the crossbar arbiter.
// Address width mirrors the interconnect's bus definition.
package arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANTED
    } arb_state_t;

    localparam int ADDR_WIDTH  = 32;
    localparam int QTY_DEFAULT = 4;
    localparam int SLAVE_SEL_W = $clog2(QTY_DEFAULT);

endpackage

// File: rtl/rr_arbiter_slice.sv
// One slave's arbiter: round-robin pick, grant hold until finish,
// optional watchdog that force-releases a stuck grant.
module rr_arbiter_slice
    import arbiter_pkg::*;
#(
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         finish_i,
    output logic [N-1:0] grant_o,
    output logic         timeout_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] widx_q, widx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] idx;
    logic          rel;

    // N is a power of two, so the index wraps naturally.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        idx     = ptr_q;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + PW'(i);
            if (!win_vld && req_i[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        widx_d  = widx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        rel     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANTED;
                    grant_d = N'(1) << win_idx;
                    widx_d  = win_idx;
                    cnt_d   = '0;
                end
            end
            GRANTED: begin
                if (finish_i) begin
                    rel = 1'b1;
                end else if (WD_EN && cnt_q == CNT_LAST) begin
                    rel   = 1'b1;
                    tmo_d = 1'b1;
                end else if (WD_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rel) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = widx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            widx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            widx_q  <= widx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o   = grant_q;
    assign timeout_o = tmo_q;

endmodule

// File: rtl/crossbar_arbiter.sv
// Per-slave round-robin arbiter producing the crossbar granted_matrix.
// Decodes targets, excludes busy masters, masks grants on finish.
module crossbar_arbiter
    import arbiter_pkg::*;
#(
    parameter int QTY_OF_DEVICES = 1 << SLAVE_SEL_W,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [QTY_OF_DEVICES-1:0]                      master_req,
    input  logic [QTY_OF_DEVICES-1:0][ADDR_WIDTH-1:0]      master_addr,
    input  logic [QTY_OF_DEVICES-1:0]                      session_is_finished,
    output logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0]  granted_matrix,
    output logic [QTY_OF_DEVICES-1:0]                      master_granted,
    output logic [QTY_OF_DEVICES-1:0]                      session_timeout
);

    localparam int Q  = QTY_OF_DEVICES;
    localparam int SW = $clog2(Q);

    logic [Q-1:0][SW-1:0] tgt;
    logic [Q-1:0][Q-1:0]  req_mat;
    logic [Q-1:0][Q-1:0]  grant_q;

    always_comb begin
        for (int m = 0; m < Q; m++) begin
            tgt[m] = master_addr[m][ADDR_WIDTH-1 -: SW];
        end
    end

    // Masked grants let a master hand over on its finish edge.
    always_comb begin
        for (int s = 0; s < Q; s++) begin
            for (int m = 0; m < Q; m++) begin
                req_mat[s][m] = master_req[m]
                              && (tgt[m] == SW'(s))
                              && !master_granted[m];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < Q; s++) begin
            granted_matrix[s] = grant_q[s] & ~{Q{session_is_finished[s]}};
        end
    end

    always_comb begin
        master_granted = '0;
        for (int s = 0; s < Q; s++) begin
            master_granted = master_granted | granted_matrix[s];
        end
    end

    for (genvar s = 0; s < Q; s++) begin : g_slice
        rr_arbiter_slice #(
            .N              (Q),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (req_mat[s]),
            .finish_i  (session_is_finished[s]),
            .grant_o   (grant_q[s]),
            .timeout_o (session_timeout[s])
        );
    end

endmodule
